xge_packet_gen: RTL and testbench



---
 rtl/xge_packet_gen.sv | 168 ++++++++++++++++
 tb/tb_xge_packet_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/xge_packet_gen.sv
// Synthetic 64-bit Ethernet frame source for 10G link bring-up.
// Frame lengths sweep MIN_LEN..MAX_LEN and byte i of frame k carries (k + i) mod 256.
module xge_packet_gen #(
  parameter int unsigned MIN_LEN    = 64,
  parameter int unsigned MAX_LEN    = 1518,
  parameter int unsigned IPG_CYCLES = 2,
  parameter int unsigned PKT_COUNT  = 0
) (
  input  logic        usclk,
  input  logic        sys_rst,
  input  logic        tx_ready,
  output logic [63:0] tx_data,
  output logic        tx_data_en,
  output logic        tx_data_sop,
  output logic        tx_data_eop,
  output logic [2:0]  tx_data_byte_vaild,
  output logic [31:0] gen_pkt_cnt
);

  localparam int LEN_W  = 14;
  localparam int BEAT_W = 12;
  localparam int GAP_W  = 16;
  localparam logic [LEN_W-1:0] MIN_L     = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(IPG_CYCLES - 1);
  localparam logic [31:0]      PKT_LIMIT = 32'(PKT_COUNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [15:0]         seq_q, seq_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [63:0]         data_q, data_d;
  logic                en_q, en_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic [2:0]          bv_q, bv_d;

  logic [LEN_W:0]      len_pad_s;
  logic [BEAT_W-1:0]   nbeats_s;
  logic [BEAT_W-1:0]   cur_beat_s;
  logic                last_s;
  logic [3:0]          nvalid_s;
  logic [7:0]          base_s;
  logic [31:0]         cnt_inc_s;
  logic                finish_s;
  logic                emit_s;

  // Lanes at or above nvalid are driven zero.
  function automatic logic [63:0] beat_bytes(input logic [7:0] base, input logic [3:0] nvalid);
    logic [63:0] d;
    d = 64'd0;
    for (int j = 0; j < 8; j++) begin
      if (4'(j) < nvalid) d[8*j +: 8] = base + 8'(j);
    end
    return d;
  endfunction

  assign len_pad_s  = {1'b0, len_q} + 15'd7;
  assign nbeats_s   = len_pad_s[LEN_W:3];
  assign cur_beat_s = (state_q == S_SEND) ? beat_q : 12'd0;
  assign last_s     = (cur_beat_s == nbeats_s - 12'd1);
  assign nvalid_s   = (last_s && (len_q[2:0] != 3'd0)) ? {1'b0, len_q[2:0]} : 4'd8;
  assign base_s     = seq_q[7:0] + {cur_beat_s[4:0], 3'b000};
  assign cnt_inc_s  = cnt_q + 32'd1;
  assign finish_s   = (PKT_LIMIT != 32'd0) && (cnt_inc_s == PKT_LIMIT);

  // Next-state and next-output logic; the beat for the coming cycle is built here.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
    seq_d   = seq_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    data_d  = 64'd0;
    en_d    = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    bv_d    = 3'd0;
    emit_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_ready) begin
          emit_s = 1'b1;
          sop_d  = 1'b1;
        end else begin
          emit_s = 1'b0;
        end
      end
      S_SEND: emit_s = 1'b1;
      S_GAP: begin
        if (gap_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (emit_s) begin
      en_d   = 1'b1;
      data_d = beat_bytes(base_s, nvalid_s);
      if (last_s) begin
        eop_d   = 1'b1;
        bv_d    = len_q[2:0];
        cnt_d   = cnt_inc_s;
        seq_d   = seq_q + 16'd1;
        len_d   = (len_q == MAX_L) ? MIN_L : len_q + 14'd1;
        beat_d  = 12'd0;
        gap_d   = GAP_LOAD;
        state_d = finish_s ? S_DONE : S_GAP;
      end else begin
        beat_d  = cur_beat_s + 12'd1;
        state_d = S_SEND;
      end
    end else begin
      en_d = 1'b0;
    end
  end

  // State and registered outputs; async reset abandons any frame in flight.
  always_ff @(posedge usclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      beat_q  <= 12'd0;
      len_q   <= MIN_L;
      seq_q   <= 16'd0;
      gap_q   <= 16'd0;
      cnt_q   <= 32'd0;
      data_q  <= 64'd0;
      en_q    <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      bv_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      seq_q   <= seq_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      bv_q    <= bv_d;
    end
  end

  assign tx_data            = data_q;
  assign tx_data_en         = en_q;
  assign tx_data_sop        = sop_q;
  assign tx_data_eop        = eop_q;
  assign tx_data_byte_vaild = bv_q;
  assign gen_pkt_cnt        = cnt_q;

endmodule

// File: tb/tb_xge_packet_gen.sv
// Randomized bench for xge_packet_gen: three parameterisations checked against a
// frame-level reference model (lengths, byte pattern, gap and ready rules).
module tb_xge_packet_gen;

  logic usclk = 1'b0;
  logic rst_a = 1'b1, rst_bc = 1'b1;
  logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
  logic rp_a = 1'b0, rp_b = 1'b0, rp_c = 1'b0;

  logic [63:0] data_a, data_b, data_c;
  logic        en_a, en_b, en_c, sop_a, sop_b, sop_c, eop_a, eop_b, eop_c;
  logic [2:0]  bv_a, bv_b, bv_c;
  logic [31:0] cnt_a, cnt_b, cnt_c;

  int n_checks = 0, n_errors = 0;

  xge_packet_gen dut_a (
    .usclk(usclk), .sys_rst(rst_a), .tx_ready(rdy_a), .tx_data(data_a), .tx_data_en(en_a),
    .tx_data_sop(sop_a), .tx_data_eop(eop_a), .tx_data_byte_vaild(bv_a), .gen_pkt_cnt(cnt_a));

  xge_packet_gen #(.MIN_LEN(9), .MAX_LEN(10), .IPG_CYCLES(1), .PKT_COUNT(0)) dut_b (
    .usclk(usclk), .sys_rst(rst_bc), .tx_ready(rdy_b), .tx_data(data_b), .tx_data_en(en_b),
    .tx_data_sop(sop_b), .tx_data_eop(eop_b), .tx_data_byte_vaild(bv_b), .gen_pkt_cnt(cnt_b));

  xge_packet_gen #(.MIN_LEN(5), .MAX_LEN(7), .IPG_CYCLES(3), .PKT_COUNT(3)) dut_c (
    .usclk(usclk), .sys_rst(rst_bc), .tx_ready(rdy_c), .tx_data(data_c), .tx_data_en(en_c),
    .tx_data_sop(sop_c), .tx_data_eop(eop_c), .tx_data_byte_vaild(bv_c), .gen_pkt_cnt(cnt_c));

  always #5 usclk = ~usclk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model state, one slot per DUT.
  localparam int MINL[3] = '{64, 9, 5};
  localparam int MAXL[3] = '{1518, 10, 7};
  localparam int IPG[3]  = '{2, 1, 3};
  localparam int PKT[3]  = '{0, 0, 3};
  int          k_m[3], len_m[3], pos_m[3], idle_m[3];
  bit          inf_m[3], done_m[3];
  logic [31:0] cnt_m[3];

  task automatic model_step(input int d, input logic rst, input logic rp, input logic en,
                            input logic sop, input logic eop, input logic [2:0] bv,
                            input logic [63:0] data, input logic [31:0] cnt);
    string       tag;
    logic [63:0] ed;
    logic        e_eop;
    logic [2:0]  e_bv;
    tag = $sformatf("dut%0d", d);
    if (rst) begin
      check_eq({tag, "_reset_out"}, {en, sop, eop, bv, data, cnt}, 128'd0);
      k_m[d] = 0; len_m[d] = MINL[d]; pos_m[d] = 0; idle_m[d] = IPG[d];
      inf_m[d] = 1'b0; done_m[d] = 1'b0; cnt_m[d] = 32'd0;
      return;
    end
    if (!inf_m[d] && !done_m[d] && idle_m[d] >= IPG[d] && rp) begin
      inf_m[d] = 1'b1;
      pos_m[d] = 0;
    end
    if (inf_m[d]) begin
      ed = 64'd0;
      for (int j = 0; j < 8; j++) begin
        if (pos_m[d] + j < len_m[d]) ed[8*j +: 8] = 8'((k_m[d] + pos_m[d] + j) % 256);
      end
      e_eop = (pos_m[d] + 8 >= len_m[d]);
      e_bv  = e_eop ? 3'(len_m[d] % 8) : 3'd0;
      check_eq({tag, "_beat"}, {en, sop, eop, bv, data},
               {1'b1, (pos_m[d] == 0), e_eop, e_bv, ed});
      pos_m[d] += 8;
      if (e_eop) begin
        inf_m[d] = 1'b0;
        k_m[d]++;
        cnt_m[d] = cnt_m[d] + 32'd1;
        len_m[d] = (len_m[d] == MAXL[d]) ? MINL[d] : len_m[d] + 1;
        idle_m[d] = 0;
        if (PKT[d] != 0 && cnt_m[d] == 32'(PKT[d])) done_m[d] = 1'b1;
      end
    end else begin
      check_eq({tag, "_idle"}, {en, sop, eop, bv, data}, 128'd0);
      idle_m[d]++;
    end
    check_eq({tag, "_pkt_cnt"}, cnt, cnt_m[d]);
  endtask

  int sum_b = 0, frames_b = 0, sops_c = 0, eops_c = 0;

  // Record tx_ready as sampled by each active edge.
  always @(posedge usclk) begin
    rp_a <= rdy_a & ~rst_a;
    rp_b <= rdy_b & ~rst_bc;
    rp_c <= rdy_c & ~rst_bc;
  end

  // Compare every cycle away from the active edge.
  always @(negedge usclk) begin
    model_step(0, rst_a, rp_a, en_a, sop_a, eop_a, bv_a, data_a, cnt_a);
    model_step(1, rst_bc, rp_b, en_b, sop_b, eop_b, bv_b, data_b, cnt_b);
    model_step(2, rst_bc, rp_c, en_c, sop_c, eop_c, bv_c, data_c, cnt_c);
    if (!rst_bc && en_b && frames_b < 4) begin
      sum_b += eop_b ? ((bv_b == 3'd0) ? 8 : int'(bv_b)) : 8;
      if (eop_b) frames_b++;
    end
    if (!rst_bc && en_c && sop_c) sops_c++;
    if (!rst_bc && en_c && eop_c) eops_c++;
  end

  initial begin
    forever begin
      @(posedge usclk); #1;
      rdy_b = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit found;
    repeat (2) @(posedge usclk);
    #1;
    check_eq("reset_state_a", {en_a, sop_a, eop_a, bv_a, data_a, cnt_a}, 128'd0);
    rst_a = 1'b0;
    rst_bc = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge usclk); #1;
      if (en_a && eop_a) found = 1'b1;
    end
    check_eq("a_first_eop_seen", found, 1'b1);

    // Backpressure right after frame 0; the model flags any early sop.
    rdy_a = 1'b0;
    repeat (20) begin @(posedge usclk); #1; end
    rdy_a = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge usclk); #1;
      if (en_a && sop_a && cnt_a == 32'd2) found = 1'b1;
      else rdy_a = ($urandom_range(0, 1) != 0);
    end
    check_eq("a_frame2_seen", found, 1'b1);
    repeat (3) begin @(posedge usclk); #1; rdy_a = ($urandom_range(0, 1) != 0); end
    rst_a = 1'b1;
    #1;
    check_eq("a_reset_midframe", {en_a, sop_a, eop_a, bv_a, data_a, cnt_a}, 128'd0);
    repeat (3) @(posedge usclk);
    #1;
    rst_a = 1'b0;
    rdy_a = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge usclk); #1;
      if (en_a && sop_a) found = 1'b1;
    end
    check_eq("a_restart_seen", found, 1'b1);
    check_eq("a_restart_frame0", {data_a, cnt_a}, {64'h0706050403020100, 32'd0});

    repeat (1200) begin @(posedge usclk); #1; rdy_a = ($urandom_range(0, 3) != 0); end

    check_eq("b_bytes_4_frames", 32'(sum_b), 32'd38);
    check_eq("c_sop_count", 32'(sops_c), 32'd3);
    check_eq("c_eop_count", 32'(eops_c), 32'd3);
    check_eq("c_final_cnt", cnt_c, 32'd3);
    check_eq("c_idle_after_done", {en_c, data_c}, 65'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
